walk_request_ctrl: RTL and testbench

//  Pedestrian-side end of the walk-signal interface. Debounces the crossing push button, raises a

---
 rtl/walk_request_ctrl.sv | 158 +++++++++++++++
 tb/tb_walk_request_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/walk_request_ctrl.sv
// Pedestrian crossing request controller: debounces the push button, requests a crossing,
// runs the WALK / flashing DONT_WALK lamp sequence and completes a 4-phase grant handshake.
module walk_request_ctrl #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned WALK_CYCLES  = 8,
  parameter int unsigned FLASH_CYCLES = 6,
  parameter int unsigned FLASH_HALF   = 1,
  parameter int unsigned CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic grant,
  output logic req,
  output logic done,
  output logic walk,
  output logic dont_walk,
  output logic wait_lit
);

  localparam logic [CNT_W-1:0] DEB_MAX    = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(FLASH_HALF - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WALK  = 3'd2,
    FLASH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_n;
  logic             sync1, btn_s;
  logic [CNT_W-1:0] deb_cnt, deb_cnt_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] half_cnt, half_cnt_n;
  logic             pending, pending_n;
  logic             press_c;
  logic             req_n, done_n, walk_n, dont_walk_n, wait_lit_n;

  // Two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn;
      btn_s <= sync1;
    end
  end

  // Saturating run-length counter: press fires once per high run, re-arms on a low sample
  always_comb begin
    deb_cnt_n = deb_cnt;
    press_c   = 1'b0;
    if (!btn_s) begin
      deb_cnt_n = '0;
    end else if (deb_cnt != DEB_MAX) begin
      deb_cnt_n = deb_cnt + CNT_W'(1);
      press_c   = (deb_cnt == DEB_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      cnt       <= '0;
      half_cnt  <= '0;
      pending   <= 1'b0;
      req       <= 1'b0;
      done      <= 1'b0;
      walk      <= 1'b0;
      dont_walk <= 1'b1;
      wait_lit  <= 1'b0;
    end else begin
      state     <= state_n;
      deb_cnt   <= deb_cnt_n;
      cnt       <= cnt_n;
      half_cnt  <= half_cnt_n;
      pending   <= pending_n;
      req       <= req_n;
      done      <= done_n;
      walk      <= walk_n;
      dont_walk <= dont_walk_n;
      wait_lit  <= wait_lit_n;
    end
  end

  // Next state, phase counters and next-cycle lamp/handshake values
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    half_cnt_n  = half_cnt;
    req_n       = 1'b0;
    done_n      = 1'b0;
    walk_n      = 1'b0;
    dont_walk_n = 1'b1;

    unique case (state)
      IDLE: begin
        if (press_c || pending) state_n = REQ;
      end
      REQ: begin
        if (grant) begin
          state_n = WALK;
          cnt_n   = WALK_LOAD;
        end
      end
      WALK: begin
        if (!grant || cnt == '0) begin
          state_n = FLASH;
          cnt_n   = FLASH_LOAD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      FLASH: begin
        if (cnt == '0) state_n = DONE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      DONE: begin
        if (!grant) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered, so they follow the state being entered
    unique case (state_n)
      REQ:  req_n = 1'b1;
      WALK: begin
        walk_n      = 1'b1;
        dont_walk_n = 1'b0;
      end
      FLASH: begin
        if (state != FLASH) begin
          half_cnt_n = HALF_LOAD;
        end else if (half_cnt == '0) begin
          dont_walk_n = ~dont_walk;
          half_cnt_n  = HALF_LOAD;
        end else begin
          dont_walk_n = dont_walk;
          half_cnt_n  = half_cnt - CNT_W'(1);
        end
      end
      DONE:    done_n = (state != DONE);
      default: ;
    endcase

    // A press outside IDLE is remembered until the next REQ is entered
    pending_n  = (pending || (press_c && state != IDLE)) && !(state_n == REQ && state != REQ);
    wait_lit_n = pending_n || (state_n == REQ);
  end

endmodule

// File: tb/tb_walk_request_ctrl.sv
// Directed bench for walk_request_ctrl: handshake, debounce, pending press, revocation, async reset.
module tb_walk_request_ctrl;

  logic clk, rst_n, btn, grant;
  logic req, done, walk, dont_walk, wait_lit;
  logic [4:0] o;
  int checks = 0;
  int errors = 0;

  walk_request_ctrl #(
    .DEB_CYCLES(4), .WALK_CYCLES(8), .FLASH_CYCLES(6), .FLASH_HALF(1), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .grant(grant),
    .req(req), .done(done), .walk(walk), .dont_walk(dont_walk), .wait_lit(wait_lit)
  );

  // Observed outputs packed as {req, done, walk, dont_walk, wait_lit}
  assign o = {req, done, walk, dont_walk, wait_lit};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn = 1'b0; grant = 1'b0;
    #2;
    repeat (3) step();
    checks++;
    if (o !== 5'b00010) begin
      errors++; $display("FAIL reset_state got %b exp %b", o, 5'b00010);
    end
  endtask

  task automatic test_basic_crossing();
    rst_n = 1'b1; btn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step(); checks++;
      if (o !== 5'b00010) begin errors++; $display("FAIL basic_deb edge %0d got %b exp %b", i, o, 5'b00010); end
    end
    step(); checks++;
    if (o !== 5'b10011) begin errors++; $display("FAIL basic_req_edge6 got %b exp %b", o, 5'b10011); end
    grant = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(); checks++;
      if (o !== 5'b00100) begin errors++; $display("FAIL basic_walk cyc %0d got %b exp %b", i, o, 5'b00100); end
    end
    for (int i = 0; i < 6; i++) begin
      step(); checks++;
      if (o !== {3'b000, (i % 2) == 0, 1'b0}) begin
        errors++; $display("FAIL basic_flash cyc %0d got %b exp %b", i, o, {3'b000, (i % 2) == 0, 1'b0});
      end
    end
    step(); checks++;
    if (o !== 5'b01010) begin errors++; $display("FAIL basic_done got %b exp %b", o, 5'b01010); end
    step(); checks++;
    if (o !== 5'b00010) begin errors++; $display("FAIL basic_done_hold got %b exp %b", o, 5'b00010); end
    grant = 1'b0; btn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); checks++;
      if (o !== 5'b00010) begin errors++; $display("FAIL basic_idle cyc %0d got %b exp %b", i, o, 5'b00010); end
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      btn = ((i / 2) % 2) == 0;
      step(); checks++;
      if (o !== 5'b00010) begin errors++; $display("FAIL bounce_no_press cyc %0d got %b exp %b", i, o, 5'b00010); end
    end
    btn = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step(); checks++;
      if (o !== 5'b00010) begin errors++; $display("FAIL bounce_hold edge %0d got %b exp %b", i, o, 5'b00010); end
    end
    for (int i = 0; i < 10; i++) begin
      step(); checks++;
      if (o !== 5'b10011) begin errors++; $display("FAIL bounce_req cyc %0d got %b exp %b", i, o, 5'b10011); end
    end
    btn = 1'b0; grant = 1'b1;
    repeat (14) step();
    step(); checks++;
    if (o !== 5'b01010) begin errors++; $display("FAIL bounce_done got %b exp %b", o, 5'b01010); end
    grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); checks++;
      if (o !== 5'b00010) begin errors++; $display("FAIL bounce_single_req cyc %0d got %b exp %b", i, o, 5'b00010); end
    end
  endtask

  task automatic test_pending_press();
    btn = 1'b1;
    repeat (6) step();
    checks++;
    if (o !== 5'b10011) begin errors++; $display("FAIL pend_req got %b exp %b", o, 5'b10011); end
    btn = 1'b0; grant = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(); checks++;
      if (o !== {4'b0010, i >= 7}) begin
        errors++; $display("FAIL pend_walk cyc %0d got %b exp %b", i, o, {4'b0010, i >= 7});
      end
      if (i == 1) btn = 1'b1;
    end
    btn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(); checks++;
      if (o !== {3'b000, (i % 2) == 0, 1'b1}) begin
        errors++; $display("FAIL pend_flash cyc %0d got %b exp %b", i, o, {3'b000, (i % 2) == 0, 1'b1});
      end
    end
    step(); checks++;
    if (o !== 5'b01011) begin errors++; $display("FAIL pend_done got %b exp %b", o, 5'b01011); end
    grant = 1'b0;
    step(); checks++;
    if (o !== 5'b00011) begin errors++; $display("FAIL pend_idle got %b exp %b", o, 5'b00011); end
    step(); checks++;
    if (o !== 5'b10011) begin errors++; $display("FAIL pend_rereq got %b exp %b", o, 5'b10011); end
  endtask

  task automatic test_revocation();
    grant = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(); checks++;
      if (o !== 5'b00100) begin errors++; $display("FAIL revoke_walk cyc %0d got %b exp %b", i, o, 5'b00100); end
    end
    grant = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(); checks++;
      if (o !== {3'b000, (i % 2) == 0, 1'b0}) begin
        errors++; $display("FAIL revoke_flash cyc %0d got %b exp %b", i, o, {3'b000, (i % 2) == 0, 1'b0});
      end
    end
    step(); checks++;
    if (o !== 5'b01010) begin errors++; $display("FAIL revoke_done got %b exp %b", o, 5'b01010); end
    for (int i = 0; i < 3; i++) begin
      step(); checks++;
      if (o !== 5'b00010) begin errors++; $display("FAIL revoke_idle cyc %0d got %b exp %b", i, o, 5'b00010); end
    end
  endtask

  task automatic test_async_reset();
    btn = 1'b1;
    repeat (6) step();
    checks++;
    if (o !== 5'b10011) begin errors++; $display("FAIL areset_pre_req got %b exp %b", o, 5'b10011); end
    grant = 1'b1;
    repeat (9) step();
    step(); checks++;
    if (o !== 5'b00000) begin errors++; $display("FAIL areset_flash2 got %b exp %b", o, 5'b00000); end
    #3 rst_n = 1'b0;
    #1 checks++;
    if (o !== 5'b00010) begin errors++; $display("FAIL areset_immediate got %b exp %b", o, 5'b00010); end
    grant = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step(); checks++;
      if (o !== 5'b00010) begin errors++; $display("FAIL areset_no_done edge %0d got %b exp %b", i, o, 5'b00010); end
    end
    step(); checks++;
    if (o !== 5'b10011) begin errors++; $display("FAIL areset_new_req got %b exp %b", o, 5'b10011); end
  endtask

  task automatic test_grant_held_in_done();
    btn = 1'b0; grant = 1'b1;
    repeat (14) step();
    step(); checks++;
    if (o !== 5'b01010) begin errors++; $display("FAIL held_done_pulse got %b exp %b", o, 5'b01010); end
    btn = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step(); checks++;
      if (o !== {4'b0001, k >= 6}) begin
        errors++; $display("FAIL held_done cyc %0d got %b exp %b", k, o, {4'b0001, k >= 6});
      end
    end
    grant = 1'b0;
    step(); checks++;
    if (o !== 5'b00011) begin errors++; $display("FAIL held_idle got %b exp %b", o, 5'b00011); end
    step(); checks++;
    if (o !== 5'b10011) begin errors++; $display("FAIL held_rereq got %b exp %b", o, 5'b10011); end
  endtask

  initial begin
    test_reset();
    test_basic_crossing();
    test_bounce();
    test_pending_press();
    test_revocation();
    test_async_reset();
    test_grant_held_in_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
